multi_edge_detector: RTL
========================

// Module: multi_edge_detector
// PURPOSE
//   N-channel debounced edge detector for asynchronous inputs (buttons, external strobes).
//   Each channel synchronises its input, filters glitches shorter than STABLE_CYCLES,
//   and emits a one-cycle pulse on the edge type selected per channel.
//   Each channel also keeps a sticky pending flag, so the FSM/controller layer can poll events.
// PARAMETERS
//   CHANNELS       4   number of independent input channels (>=1)
//   STABLE_CYCLES  4   consecutive mismatching samples required to accept a new level (>=1)
//   CNT_W          $clog2(STABLE_CYCLES+1)   debounce counter width (derived, do not override)
// PORTS
//   clk      in   1             system clock, all logic on rising edge
//   rst      in   1             synchronous, active-high reset
//   x        in   CHANNELS      raw asynchronous inputs
//   mode     in   2*CHANNELS    per-channel edge select, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//   clr      in   CHANNELS      per-channel pending clear (1-cycle strobe or level)
//   z        out  CHANNELS      one-cycle event pulse per channel (registered)
//   level    out  CHANNELS      debounced level per channel
//   pend     out  CHANNELS      sticky event flags
//   any_evt  out  1             |pend (combinational OR of registered flags)
// BEHAVIOUR
//   - Reset (rst=1 at clk edge): sync flops=0, level=0, counters=0, z=0, pend=0, state=S_LOW.
//   - Sync: 2-flop synchroniser per channel, x -> s1 -> s2. Only s2 feeds the FSM.
//   - Per-channel FSM (S_LOW, S_RISING, S_HIGH, S_FALLING):
//       S_LOW:     s2=1 -> S_RISING, cnt=1; else stay, cnt=0
//       S_RISING:  s2=0 -> S_LOW, cnt=0 (glitch rejected)
//                  s2=1 and cnt==STABLE_CYCLES -> S_HIGH
//                  else cnt+1
//       S_HIGH / S_FALLING: mirror images of the above, with s2 inverted.
//     STABLE_CYCLES=1: S_LOW->S_HIGH directly on the first s2=1 sample; no intermediate state.
//   - level=1 exactly in S_HIGH and S_FALLING; level updates on the same edge as the state commit.
//   - Event: a rise is the commit into S_HIGH; a fall is the commit into S_LOW from S_FALLING.
//     z[i]=1 for exactly one cycle, on the cycle level changes, only if mode[i] enables that edge type.
//   - Latency: x stable from before edge k -> level/z change after edge k+1+STABLE_CYCLES.
//     Example: STABLE_CYCLES=4 gives 5 clocks from the first sampling edge.
//   - Pulses shorter than STABLE_CYCLES samples (after sync) never change level and never pulse.
//   - pend[i]: set on each z[i]; cleared by clr[i]. Set and clear in the same cycle -> set wins (stays 1).
//   - mode is sampled at the commit edge. Changing mode mid-debounce is legal and does not restart the counter.
//     mode=00 still tracks level, but suppresses z and pend.
//   - Counter saturates at STABLE_CYCLES, never wraps. Channels are fully independent.
//   - Reset mid-debounce aborts all channels to S_LOW.
//     An input held high through reset yields a rise event STABLE_CYCLES+2 cycles after rst deasserts.
// STRUCTURE
//   - Package edge_det_pkg: MODE_OFF/MODE_RISE/MODE_FALL/MODE_BOTH (2-bit) and FSM state encodings (2-bit).
//   - Sub-module edge_det_channel: synchroniser, FSM, counter, z and pend for one channel.
//     Parameter STABLE_CYCLES.
//   - Top level: generate loop over CHANNELS plus the any_evt OR-reduce. No logic shared between channels.
// TESTING
//   1. Reset: drive x=all 1 with rst held 3 cycles.
//      -> z=0, level=0, pend=0 during reset.
//      -> With mode=01, z[i] pulses once at cycle STABLE_CYCLES+2 after release.
//   2. Clean rise, ch0, mode=01, S=4: x[0] 0->1 held.
//      -> level[0] rises and z[0]=1 for 1 cycle, 5 cycles after the first sampling edge.
//      -> pend[0]=1 and any_evt=1.
//   3. Glitch: x[1] high for 3 cycles (S=4), mode=11.
//      -> level[1], z[1] and pend[1] stay 0.
//      -> The 4-cycle pulse case does produce a rise pulse.
//   4. Mode filter: ch2 with mode=10, full high pulse.
//      -> No z on the rise; z[2] on the fall only.
//      -> Repeat with mode=00: level toggles, z and pend stay 0.
//   5. Clear race: assert clr[3] on the same cycle as z[3].
//      -> pend[3] remains 1.
//      -> clr[3] on the next cycle -> pend[3]=0, and any_evt drops if no other pend is set.
//   6. Independence: toggle all channels with staggered timing and mixed modes.
//      -> Each z matches a per-channel reference model exactly, cycle for cycle.

Source files
------------

// File: rtl/edge_det_pkg.sv
// Shared encodings for the multi-channel debounced edge detector: per-channel
// edge-select codes, debounce FSM states and edge-enable decode helpers.
package edge_det_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } edge_mode_t;

    typedef enum logic [1:0] {
        S_LOW     = 2'b00,
        S_RISING  = 2'b01,
        S_HIGH    = 2'b10,
        S_FALLING = 2'b11
    } state_t;

    function automatic logic rise_en(input edge_mode_t m);
        return (m == MODE_RISE) || (m == MODE_BOTH);
    endfunction

    function automatic logic fall_en(input edge_mode_t m);
        return (m == MODE_FALL) || (m == MODE_BOTH);
    endfunction

endpackage

// File: rtl/edge_det_channel.sv
// One debounced edge-detector channel: 2-flop synchroniser, 4-state debounce
// FSM with saturating counter, registered event pulse and sticky pending flag.
module edge_det_channel
    import edge_det_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       x,
    input  logic [1:0] mode,
    input  logic       clr,
    output logic       z,
    output logic       level,
    output logic       pend
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    // The new level is accepted on the STABLE_CYCLES-th consecutive mismatching
    // sample; cnt already holds the samples seen before the current one.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             s1;
    logic             s2;
    logic             rise_ok;
    logic             fall_ok;

    assign rise_ok = rise_en(edge_mode_t'(mode));
    assign fall_ok = fall_en(edge_mode_t'(mode));

    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= S_LOW;
            cnt   <= '0;
            level <= 1'b0;
            z     <= 1'b0;
            pend  <= 1'b0;
        end else begin
            s1   <= x;
            s2   <= s1;
            z    <= 1'b0;
            // A same-edge event overrides this clear below, so set wins.
            pend <= pend & ~clr;
            unique case (state)
                S_LOW: begin
                    if (s2) begin
                        if (STABLE_CYCLES == 1) begin
                            state <= S_HIGH;
                            level <= 1'b1;
                            cnt   <= '0;
                            if (rise_ok) begin
                                z    <= 1'b1;
                                pend <= 1'b1;
                            end
                        end else begin
                            state <= S_RISING;
                            cnt   <= CNT_W'(1);
                        end
                    end else begin
                        cnt <= '0;
                    end
                end
                S_RISING: begin
                    if (!s2) begin
                        state <= S_LOW;
                        cnt   <= '0;
                    end else if (cnt >= CNT_LAST) begin
                        state <= S_HIGH;
                        level <= 1'b1;
                        cnt   <= '0;
                        if (rise_ok) begin
                            z    <= 1'b1;
                            pend <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_HIGH: begin
                    if (!s2) begin
                        if (STABLE_CYCLES == 1) begin
                            state <= S_LOW;
                            level <= 1'b0;
                            cnt   <= '0;
                            if (fall_ok) begin
                                z    <= 1'b1;
                                pend <= 1'b1;
                            end
                        end else begin
                            state <= S_FALLING;
                            cnt   <= CNT_W'(1);
                        end
                    end else begin
                        cnt <= '0;
                    end
                end
                S_FALLING: begin
                    if (s2) begin
                        state <= S_HIGH;
                        cnt   <= '0;
                    end else if (cnt >= CNT_LAST) begin
                        state <= S_LOW;
                        level <= 1'b0;
                        cnt   <= '0;
                        if (fall_ok) begin
                            z    <= 1'b1;
                            pend <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_LOW;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/multi_edge_detector.sv
// N independent debounced edge-detector channels with a combined
// "any event pending" flag for polling controllers.
module multi_edge_detector #(
    parameter int CHANNELS      = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CHANNELS-1:0]   x,
    input  logic [2*CHANNELS-1:0] mode,
    input  logic [CHANNELS-1:0]   clr,
    output logic [CHANNELS-1:0]   z,
    output logic [CHANNELS-1:0]   level,
    output logic [CHANNELS-1:0]   pend,
    output logic                  any_evt
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        edge_det_channel #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .x    (x[i]),
            .mode (mode[2*i+1 -: 2]),
            .clr  (clr[i]),
            .z    (z[i]),
            .level(level[i]),
            .pend (pend[i])
        );
    end

    assign any_evt = |pend;

endmodule
